max_pool_unit: RTL

- Max-pooling stage directly upstream of the destination buffer.
- Consumes a stream of activations grouped into pooling windows. Each window is delimited by first/last flags.
- Per window, emits one result to the destination buffer write port: the max value (po), its source pointer (pp), a write strobe (outr) and a write address (oa).
- Also tracks the window element count and flags protocol errors.

---
 rtl/max_pool_unit_if.sv | 27 ++
 rtl/max_pool_unit.sv | 115 +++++++++++
 2 files changed

// File: rtl/max_pool_unit_if.sv
// max_pool_unit_if: activation stream into the pooling stage and pooled result out to the destination buffer
interface max_pool_unit_if #(
    parameter int DW = 32,
    parameter int PW = 16,
    parameter int AW = 13
);
    logic                 in_v;
    logic                 in_first;
    logic                 in_last;
    logic signed [DW-1:0] in_d;
    logic [PW-1:0]        in_p;
    logic [AW-1:0]        in_oa;
    logic                 outr;
    logic [AW-1:0]        oa;
    logic signed [DW-1:0] po;
    logic [PW-1:0]        pp;

    modport master (
        output in_v, in_first, in_last, in_d, in_p, in_oa,
        input  outr, oa, po, pp
    );

    modport slave (
        input  in_v, in_first, in_last, in_d, in_p, in_oa,
        output outr, oa, po, pp
    );
endinterface

// File: rtl/max_pool_unit.sv
// max_pool_unit: per-window signed max with pointer, one result strobe per window; define MAX_POOL_RELU_EN to clamp negative results to 0
module max_pool_unit #(
    parameter int DW   = 32,
    parameter int PW   = 16,
    parameter int AW   = 13,
    parameter int KMAX = 9
) (
    input  logic                  clk,
    input  logic                  rst_n,
    max_pool_unit_if.slave        bus,
    output logic                  busy,
    output logic [3:0]            cnt,
    output logic                  err
);
    typedef enum logic [0:0] {IDLE, ACC} state_t;

    state_t               state, state_n;
    logic signed [DW-1:0] max_r, max_n;
    logic [PW-1:0]        ptr_r, ptr_n;
    logic [AW-1:0]        addr_r, addr_n;
    logic [3:0]           cnt_r, cnt_n;
    logic                 err_r, err_n;
    logic                 emit;
    logic signed [DW-1:0] emit_d, res_d;
    logic [PW-1:0]        emit_p;
    logic [AW-1:0]        emit_a;
    logic                 start, acc_beat, gt;

    assign start    = bus.in_v && bus.in_first;
    assign acc_beat = bus.in_v && !bus.in_first && state == ACC;
    assign gt       = bus.in_d > max_r;

    // Window bookkeeping: open/restart on in_first, fold in elements, close on in_last
    always_comb begin
        state_n = state;
        max_n   = max_r;
        ptr_n   = ptr_r;
        addr_n  = addr_r;
        cnt_n   = cnt_r;
        err_n   = err_r;
        emit    = 1'b0;
        emit_d  = max_r;
        emit_p  = ptr_r;
        emit_a  = addr_r;
        if (start) begin
            err_n   = err_r || state == ACC;
            max_n   = bus.in_d;
            ptr_n   = bus.in_p;
            addr_n  = bus.in_oa;
            cnt_n   = bus.in_last ? 4'd0 : 4'd1;
            state_n = bus.in_last ? IDLE : ACC;
            emit    = bus.in_last;
            emit_d  = bus.in_d;
            emit_p  = bus.in_p;
            emit_a  = bus.in_oa;
        end else if (acc_beat) begin
            err_n   = err_r || cnt_r >= 4'(KMAX);
            max_n   = gt ? bus.in_d : max_r;
            ptr_n   = gt ? bus.in_p : ptr_r;
            cnt_n   = bus.in_last ? 4'd0 : (cnt_r == 4'hF ? 4'hF : cnt_r + 4'd1);
            state_n = bus.in_last ? IDLE : ACC;
            emit    = bus.in_last;
            emit_d  = max_n;
            emit_p  = ptr_n;
        end else if (bus.in_v) begin
            err_n = 1'b1;
        end
    end

`ifdef MAX_POOL_RELU_EN
    assign res_d = emit_d[DW-1] ? '0 : emit_d;
`else
    assign res_d = emit_d;
`endif

    // Window state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            max_r  <= '0;
            ptr_r  <= '0;
            addr_r <= '0;
            cnt_r  <= '0;
            err_r  <= 1'b0;
        end else begin
            state  <= state_n;
            max_r  <= max_n;
            ptr_r  <= ptr_n;
            addr_r <= addr_n;
            cnt_r  <= cnt_n;
            err_r  <= err_n;
        end
    end

    // Result port: strobe for one cycle, data held until the next emit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.outr <= 1'b0;
            bus.oa   <= '0;
            bus.po   <= '0;
            bus.pp   <= '0;
        end else begin
            bus.outr <= emit;
            if (emit) begin
                bus.oa <= emit_a;
                bus.po <= res_d;
                bus.pp <= emit_p;
            end
        end
    end

    assign busy = state == ACC;
    assign cnt  = cnt_r;
    assign err  = err_r;
endmodule
